// File: rtl/sa_wrr_arbiter.sv
// sa_wrr_arbiter: weighted round-robin arbiter issuing one registered grant per valid/ready handshake
module sa_wrr_arbiter #(
    parameter int MST_AMT = 4,
    parameter logic [0:(MST_AMT*32)-1] MST_WEIGHT = {32'd5, 32'd3, 32'd2, 32'd1},
    parameter int MST_ID_W = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
    parameter int CREDIT_W = 8
) (
    input  logic                ACLK_i,
    input  logic                ARESET_i,
    input  logic [MST_AMT-1:0]  req_i,
    input  logic [MST_AMT-1:0]  full_i,
    input  logic                stall_i,
    input  logic                grant_ready_i,
    output logic                grant_valid_o,
    output logic [MST_ID_W-1:0] grant_id_o,
    output logic [MST_AMT-1:0]  grant_onehot_o,
    output logic [CREDIT_W-1:0] credit_o
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [MST_ID_W-1:0]   r_owner;
    logic [CREDIT_W-1:0]   r_credit;
    logic [MST_AMT-1:0]    w_elig;
    logic [CREDIT_W-1:0]   w_weff [MST_AMT];
    logic [MST_ID_W-1:0]   w_cand;
    logic [MST_ID_W-1:0]   w_pick;
    logic                  w_keep;
    logic                  w_load;
    logic [MST_AMT-1:0]    w_onehot;

    for (genvar g = 0; g < MST_AMT; g++) begin : g_weight
        localparam logic [31:0] W = MST_WEIGHT[g*32 +: 32];
        assign w_weff[g] = (W[CREDIT_W-1:0] == '0) ? CREDIT_W'(1) : W[CREDIT_W-1:0];
    end

    assign w_elig = req_i & ~full_i;
    assign w_keep = w_elig[r_owner] && (r_credit != '0);
    assign w_load = ~stall_i && (|w_elig) && ((r_state == IDLE) || grant_ready_i);

    // Descending scan so the nearest eligible master after the owner wins; the owner itself is last.
    always_comb begin
        w_pick = r_owner;
        w_cand = r_owner;
        for (int i = MST_AMT; i >= 1; i--) begin
            w_cand = MST_ID_W'((int'(r_owner) + i) % MST_AMT);
            if (w_elig[w_cand]) w_pick = w_cand;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) w_state_nxt = GRANT;
        else if (r_state == GRANT && grant_ready_i) w_state_nxt = IDLE;
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            r_state  <= IDLE;
            r_owner  <= MST_ID_W'(MST_AMT - 1);
            r_credit <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_owner  <= w_keep ? r_owner : w_pick;
                r_credit <= w_keep ? r_credit - CREDIT_W'(1) : w_weff[w_pick] - CREDIT_W'(1);
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        if (r_state == GRANT) w_onehot[r_owner] = 1'b1;
    end

    assign grant_valid_o  = (r_state == GRANT);
    assign grant_id_o     = (r_state == GRANT) ? r_owner : '0;
    assign grant_onehot_o = w_onehot;
    assign credit_o       = r_credit;
endmodule
